// File: rtl/int_exec_pkg.sv
// Shared opcode encodings and execution-FSM state type for the integer execution stage.
package int_exec_pkg;

  localparam logic [3:0] OP_ADD  = 4'd0;
  localparam logic [3:0] OP_SUB  = 4'd1;
  localparam logic [3:0] OP_AND  = 4'd2;
  localparam logic [3:0] OP_OR   = 4'd3;
  localparam logic [3:0] OP_XOR  = 4'd4;
  localparam logic [3:0] OP_SLL  = 4'd5;
  localparam logic [3:0] OP_SRL  = 4'd6;
  localparam logic [3:0] OP_SRA  = 4'd7;
  localparam logic [3:0] OP_SLT  = 4'd8;
  localparam logic [3:0] OP_SLTU = 4'd9;
  localparam logic [3:0] OP_MUL  = 4'd10;

  typedef enum logic [1:0] {
    ST_IDLE     = 2'd0,
    ST_MUL_BUSY = 2'd1,
    ST_MUL_WAIT = 2'd2
  } exec_state_e;

endpackage

// File: rtl/exec_result_fifo.sv
// Small result buffer feeding the CDB; oldest entry is always presented on head.
module exec_result_fifo
  import int_exec_pkg::*;
#(
  parameter int WIDTH = 38,
  parameter int DEPTH = 2
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       push,
  input  logic [WIDTH-1:0]           push_data,
  input  logic                       pop,
  output logic [$clog2(DEPTH):0]     count,
  output logic [WIDTH-1:0]           head
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [WIDTH-1:0] mem_d [DEPTH];
  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0] count_q, count_d;

  always_comb begin
    mem_d    = mem_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (push) begin
      mem_d[wr_ptr_q] = push_data;
      wr_ptr_d        = wr_ptr_q + PTR_W'(1);
    end
    if (pop) begin
      rd_ptr_d = rd_ptr_q + PTR_W'(1);
    end
    case ({push, pop})
      2'b10:   count_d = count_q + CNT_W'(1);
      2'b01:   count_d = count_q - CNT_W'(1);
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      mem_q    <= '{default: '0};
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      mem_q    <= mem_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  assign count = count_q;
  assign head  = mem_q[rd_ptr_q];

endmodule

// File: rtl/int_exec_unit.sv
// Integer execution stage: single-cycle ALU, multi-cycle MUL, result FIFO and CDB handshake.
//   state       | meaning
//   ST_IDLE     | accepting; ALU results pushed on the accept edge
//   ST_MUL_BUSY | MUL in flight, down-counter running to terminal count 1
//   ST_MUL_WAIT | MUL result ready but FIFO full; pushed once a slot is free
module int_exec_unit
  import int_exec_pkg::*;
#(
  parameter int DATA_WIDTH  = 32,
  parameter int TAG_WIDTH   = 6,
  parameter int MUL_LATENCY = 3,
  parameter int FIFO_DEPTH  = 2
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  issueque_valid,
  input  logic [3:0]            issueque_opcode,
  input  logic [DATA_WIDTH-1:0] issueque_rs1_data,
  input  logic [DATA_WIDTH-1:0] issueque_rs2_data,
  input  logic [TAG_WIDTH-1:0]  issueque_rd_tag,
  output logic                  exec_ready,
  output logic                  cdb_request,
  input  logic                  cdb_grant,
  output logic                  cdb_valid,
  output logic [TAG_WIDTH-1:0]  cdb_tag,
  output logic [DATA_WIDTH-1:0] CDB_data
);

  localparam int ENTRY_W = TAG_WIDTH + DATA_WIDTH;
  localparam int FCNT_W  = $clog2(FIFO_DEPTH) + 1;
  localparam int CNT_W   = $clog2(MUL_LATENCY);
  localparam logic [CNT_W-1:0] CNT_INIT = CNT_W'(MUL_LATENCY - 1);

  exec_state_e           state_q, state_d;
  logic [CNT_W-1:0]      cnt_q, cnt_d;
  logic [DATA_WIDTH-1:0] op_a_q, op_a_d;
  logic [DATA_WIDTH-1:0] op_b_q, op_b_d;
  logic [TAG_WIDTH-1:0]  tag_q, tag_d;

  logic [DATA_WIDTH-1:0] alu_result;
  logic [DATA_WIDTH-1:0] mul_result;
  logic [4:0]            shamt;
  logic                  accept;
  logic                  fifo_full;
  logic                  fifo_push;
  logic [ENTRY_W-1:0]    fifo_push_data;
  logic                  fifo_pop;
  logic [FCNT_W-1:0]     fifo_count;
  logic [ENTRY_W-1:0]    fifo_head;

  assign fifo_full  = (fifo_count == FCNT_W'(FIFO_DEPTH));
  assign exec_ready = (state_q == ST_IDLE) && !fifo_full && !reset;
  assign accept     = issueque_valid && exec_ready;
  assign shamt      = issueque_rs2_data[4:0];
  assign mul_result = op_a_q * op_b_q;

  always_comb begin
    alu_result = '0;
    case (issueque_opcode)
      OP_ADD:  alu_result = issueque_rs1_data + issueque_rs2_data;
      OP_SUB:  alu_result = issueque_rs1_data - issueque_rs2_data;
      OP_AND:  alu_result = issueque_rs1_data & issueque_rs2_data;
      OP_OR:   alu_result = issueque_rs1_data | issueque_rs2_data;
      OP_XOR:  alu_result = issueque_rs1_data ^ issueque_rs2_data;
      OP_SLL:  alu_result = issueque_rs1_data << shamt;
      OP_SRL:  alu_result = issueque_rs1_data >> shamt;
      OP_SRA:  alu_result = $signed(issueque_rs1_data) >>> shamt;
      OP_SLT:  alu_result = {{(DATA_WIDTH-1){1'b0}},
                             $signed(issueque_rs1_data) < $signed(issueque_rs2_data)};
      OP_SLTU: alu_result = {{(DATA_WIDTH-1){1'b0}}, issueque_rs1_data < issueque_rs2_data};
      default: alu_result = '0;
    endcase
  end

  always_comb begin
    state_d        = state_q;
    cnt_d          = cnt_q;
    op_a_d         = op_a_q;
    op_b_d         = op_b_q;
    tag_d          = tag_q;
    fifo_push      = 1'b0;
    fifo_push_data = {issueque_rd_tag, alu_result};
    case (state_q)
      ST_IDLE: begin
        if (accept) begin
          if (issueque_opcode == OP_MUL) begin
            op_a_d  = issueque_rs1_data;
            op_b_d  = issueque_rs2_data;
            tag_d   = issueque_rd_tag;
            cnt_d   = CNT_INIT;
            state_d = ST_MUL_BUSY;
          end else begin
            fifo_push = 1'b1;
          end
        end
      end
      ST_MUL_BUSY: begin
        if (cnt_q == CNT_W'(1)) begin
          cnt_d = '0;
          if (!fifo_full) begin
            fifo_push      = 1'b1;
            fifo_push_data = {tag_q, mul_result};
            state_d        = ST_IDLE;
          end else begin
            state_d = ST_MUL_WAIT;
          end
        end else begin
          cnt_d = cnt_q - CNT_W'(1);
        end
      end
      ST_MUL_WAIT: begin
        // Full/not-full is judged on the count before this edge's pop.
        if (!fifo_full) begin
          fifo_push      = 1'b1;
          fifo_push_data = {tag_q, mul_result};
          state_d        = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
      op_a_q  <= '0;
      op_b_q  <= '0;
      tag_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      op_a_q  <= op_a_d;
      op_b_q  <= op_b_d;
      tag_q   <= tag_d;
    end
  end

  // Gated by reset so buffered results are never offered while being discarded.
  assign cdb_request = (fifo_count != '0) && !reset;
  assign cdb_valid   = cdb_request && cdb_grant;
  assign fifo_pop    = cdb_valid;
  assign {cdb_tag, CDB_data} = cdb_request ? fifo_head : '0;

  exec_result_fifo #(
    .WIDTH (ENTRY_W),
    .DEPTH (FIFO_DEPTH)
  ) u_result_fifo (
    .clk       (clk),
    .reset     (reset),
    .push      (fifo_push),
    .push_data (fifo_push_data),
    .pop       (fifo_pop),
    .count     (fifo_count),
    .head      (fifo_head)
  );

endmodule

// File: tb/tb_int_exec_unit.sv
// Directed bench for int_exec_unit: ALU vector table plus MUL, back-pressure and reset sequences.
module tb_int_exec_unit;
  import int_exec_pkg::*;

  logic        clk;
  logic        reset;
  logic        issueque_valid;
  logic [3:0]  issueque_opcode;
  logic [31:0] issueque_rs1_data;
  logic [31:0] issueque_rs2_data;
  logic [5:0]  issueque_rd_tag;
  logic        exec_ready;
  logic        cdb_request;
  logic        cdb_grant;
  logic        cdb_valid;
  logic [5:0]  cdb_tag;
  logic [31:0] CDB_data;

  int total = 0;
  int bad   = 0;

  typedef struct {
    logic [3:0]  op;
    logic [31:0] a;
    logic [31:0] b;
    logic [5:0]  tag;
    logic [31:0] exp;
  } vec_t;

  vec_t vecs[14];

  int_exec_unit dut (
    .clk               (clk),
    .reset             (reset),
    .issueque_valid    (issueque_valid),
    .issueque_opcode   (issueque_opcode),
    .issueque_rs1_data (issueque_rs1_data),
    .issueque_rs2_data (issueque_rs2_data),
    .issueque_rd_tag   (issueque_rd_tag),
    .exec_ready        (exec_ready),
    .cdb_request       (cdb_request),
    .cdb_grant         (cdb_grant),
    .cdb_valid         (cdb_valid),
    .cdb_tag           (cdb_tag),
    .CDB_data          (CDB_data)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1, "watchdog");
  end

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic issue(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b,
                       input logic [5:0] tag);
    issueque_valid    = 1'b1;
    issueque_opcode   = op;
    issueque_rs1_data = a;
    issueque_rs2_data = b;
    issueque_rd_tag   = tag;
  endtask

  initial begin
    vecs[0]  = '{OP_ADD,  32'd5,          32'd7,          6'd3,  32'd12};
    vecs[1]  = '{OP_SUB,  32'd0,          32'd1,          6'd4,  32'hFFFF_FFFF};
    vecs[2]  = '{OP_SRA,  32'h8000_0000,  32'd4,          6'd5,  32'hF800_0000};
    vecs[3]  = '{OP_SLTU, 32'd1,          32'hFFFF_FFFF,  6'd6,  32'd1};
    vecs[4]  = '{4'd13,   32'd123,        32'd456,        6'd7,  32'd0};
    vecs[5]  = '{OP_AND,  32'hF0F0_F0F0,  32'hFF00_FF00,  6'd8,  32'hF000_F000};
    vecs[6]  = '{OP_OR,   32'hF0F0_F0F0,  32'hFF00_FF00,  6'd11, 32'hFFF0_FFF0};
    vecs[7]  = '{OP_XOR,  32'hF0F0_F0F0,  32'hFF00_FF00,  6'd12, 32'h0FF0_0FF0};
    vecs[8]  = '{OP_SLL,  32'd1,          32'd33,         6'd13, 32'd2};
    vecs[9]  = '{OP_SRL,  32'h8000_0000,  32'd31,         6'd14, 32'd1};
    vecs[10] = '{OP_SLT,  32'hFFFF_FFFF,  32'd1,          6'd15, 32'd1};
    vecs[11] = '{OP_SLT,  32'd1,          32'hFFFF_FFFF,  6'd16, 32'd0};
    vecs[12] = '{OP_ADD,  32'hFFFF_FFFF,  32'd1,          6'd17, 32'd0};
    vecs[13] = '{OP_SLTU, 32'hFFFF_FFFF,  32'd1,          6'd63, 32'd0};

    reset             = 1'b1;
    issueque_valid    = 1'b0;
    issueque_opcode   = '0;
    issueque_rs1_data = '0;
    issueque_rs2_data = '0;
    issueque_rd_tag   = '0;
    cdb_grant         = 1'b0;

    tick();
    tick();
    check("rst_ready", 64'(exec_ready), 64'd0);
    check("rst_request", 64'(cdb_request), 64'd0);
    check("rst_valid", 64'(cdb_valid), 64'd0);
    check("rst_tag", 64'(cdb_tag), 64'd0);
    check("rst_data", 64'(CDB_data), 64'd0);
    reset = 1'b0;
    #1;
    check("post_rst_ready", 64'(exec_ready), 64'd1);

    // Grant while empty is ignored.
    cdb_grant = 1'b1;
    #1;
    check("empty_grant_valid", 64'(cdb_valid), 64'd0);
    check("empty_grant_tag", 64'(cdb_tag), 64'd0);

    // ALU table, back-to-back with grant held high.
    for (int i = 0; i < 14; i++) begin
      issue(vecs[i].op, vecs[i].a, vecs[i].b, vecs[i].tag);
      #1;
      check($sformatf("vec%0d_ready", i), 64'(exec_ready), 64'd1);
      tick();
      check($sformatf("vec%0d_valid", i), 64'(cdb_valid), 64'd1);
      check($sformatf("vec%0d_tag", i), 64'(cdb_tag), 64'(vecs[i].tag));
      check($sformatf("vec%0d_data", i), 64'(CDB_data), 64'(vecs[i].exp));
    end
    issueque_valid = 1'b0;
    tick();
    check("drain_request", 64'(cdb_request), 64'd0);

    // MUL followed by held ADD.
    issue(OP_MUL, 32'h0001_0000, 32'h0001_0000, 6'd9);
    #1;
    check("mul_ready_pre", 64'(exec_ready), 64'd1);
    tick();
    issue(OP_ADD, 32'd2, 32'd3, 6'd10);
    #1;
    check("mul_busy_ready1", 64'(exec_ready), 64'd0);
    tick();
    check("mul_busy_ready2", 64'(exec_ready), 64'd0);
    check("mul_busy_request", 64'(cdb_request), 64'd0);
    tick();
    check("mul_valid", 64'(cdb_valid), 64'd1);
    check("mul_tag", 64'(cdb_tag), 64'd9);
    check("mul_data", 64'(CDB_data), 64'd0);
    check("mul_done_ready", 64'(exec_ready), 64'd1);
    tick();
    check("add_after_mul_tag", 64'(cdb_tag), 64'd10);
    check("add_after_mul_data", 64'(CDB_data), 64'd5);
    issueque_valid = 1'b0;
    tick();
    check("mul_drain_request", 64'(cdb_request), 64'd0);

    // Back-pressure: three ALU ops with grant low.
    cdb_grant = 1'b0;
    issue(OP_ADD, 32'd1, 32'd1, 6'd20);
    tick();
    issue(OP_ADD, 32'd2, 32'd2, 6'd21);
    #1;
    check("bp_ready1", 64'(exec_ready), 64'd1);
    tick();
    issue(OP_ADD, 32'd3, 32'd3, 6'd22);
    #1;
    check("bp_full_ready", 64'(exec_ready), 64'd0);
    check("bp_request", 64'(cdb_request), 64'd1);
    check("bp_valid", 64'(cdb_valid), 64'd0);
    check("bp_head_tag", 64'(cdb_tag), 64'd20);
    check("bp_head_data", 64'(CDB_data), 64'd2);
    tick();
    check("bp_hold_ready", 64'(exec_ready), 64'd0);
    check("bp_hold_tag", 64'(cdb_tag), 64'd20);
    cdb_grant = 1'b1;
    #1;
    check("bp_grant_valid", 64'(cdb_valid), 64'd1);
    check("bp_no_comb_ready", 64'(exec_ready), 64'd0);
    tick();
    check("bp_second_tag", 64'(cdb_tag), 64'd21);
    check("bp_second_data", 64'(CDB_data), 64'd4);
    check("bp_ready_again", 64'(exec_ready), 64'd1);
    tick();
    check("bp_third_tag", 64'(cdb_tag), 64'd22);
    check("bp_third_data", 64'(CDB_data), 64'd6);
    issueque_valid = 1'b0;
    tick();
    check("bp_drain_request", 64'(cdb_request), 64'd0);

    // MUL completing into a FIFO that then becomes full, single grant pulse.
    cdb_grant = 1'b0;
    issue(OP_ADD, 32'd10, 32'd20, 6'd30);
    tick();
    issue(OP_MUL, 32'd7, 32'd6, 6'd31);
    #1;
    check("mf_ready", 64'(exec_ready), 64'd1);
    tick();
    issueque_valid = 1'b0;
    tick();
    tick();
    check("mf_full_ready", 64'(exec_ready), 64'd0);
    check("mf_head_tag", 64'(cdb_tag), 64'd30);
    check("mf_head_data", 64'(CDB_data), 64'd30);
    for (int k = 0; k < 5; k++) tick();
    check("mf_hold_tag", 64'(cdb_tag), 64'd30);
    check("mf_hold_ready", 64'(exec_ready), 64'd0);
    cdb_grant = 1'b1;
    #1;
    check("mf_pulse_valid", 64'(cdb_valid), 64'd1);
    tick();
    cdb_grant = 1'b0;
    #1;
    check("mf_mul_tag", 64'(cdb_tag), 64'd31);
    check("mf_mul_data", 64'(CDB_data), 64'd42);
    check("mf_ready_after", 64'(exec_ready), 64'd1);
    check("mf_no_valid", 64'(cdb_valid), 64'd0);
    cdb_grant = 1'b1;
    tick();
    check("mf_drain_request", 64'(cdb_request), 64'd0);

    // Reset during MUL_BUSY with one buffered result.
    cdb_grant = 1'b0;
    issue(OP_ADD, 32'd1, 32'd2, 6'd40);
    tick();
    issue(OP_MUL, 32'd3, 32'd3, 6'd41);
    tick();
    issueque_valid = 1'b0;
    reset     = 1'b1;
    cdb_grant = 1'b1;
    #1;
    check("rmid_request", 64'(cdb_request), 64'd0);
    check("rmid_valid", 64'(cdb_valid), 64'd0);
    check("rmid_ready", 64'(exec_ready), 64'd0);
    tick();
    check("rmid_request2", 64'(cdb_request), 64'd0);
    reset = 1'b0;
    #1;
    check("rmid_ready_after", 64'(exec_ready), 64'd1);
    for (int k = 0; k < 4; k++) begin
      tick();
      check($sformatf("rmid_no_result%0d", k), 64'(cdb_request), 64'd0);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
